// File: rtl/uic_seq_pkg.sv
// Shared definitions for the UIC interrupt entry sequencer:
// state encoding, MSR bit positions and default vectors.
package uic_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      ENTER  = 2'd2,
      SETTLE = 2'd3
   } seq_state_e;

   localparam int MSR_EE = 17;
   localparam int MSR_CE = 14;

   localparam logic [31:0] EXT_VEC_DEF   = 32'h0000_0500;
   localparam logic [31:0] CRIT_VEC_DEF  = 32'h0000_0100;
   localparam int          FLUSH_TMO_DEF = 16;

   // A zero UIC vector register means "not programmed": use the fixed vector.
   function automatic logic [31:0] crit_target(input logic [31:0] uicvr,
                                               input logic [31:0] dflt);
      return (uicvr != 32'd0) ? uicvr : dflt;
   endfunction

endpackage

// File: rtl/uic_seq_stat.sv
// Entry statistics for the UIC sequencer: per-class entry counters and the
// longest flush residency seen. All values saturate.
module uic_seq_stat (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_flush,
   input  logic        enter_crit,
   input  logic        enter_noncrit,
   output logic [15:0] crit_cnt,
   output logic [15:0] noncrit_cnt,
   output logic [7:0]  max_flush_lat
);

   logic [7:0] cur_lat;
   logic [7:0] cur_lat_inc;

   assign cur_lat_inc = (cur_lat == 8'hFF) ? 8'hFF : cur_lat + 8'd1;

   // Saturating per-class entry counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crit_cnt    <= 16'd0;
         noncrit_cnt <= 16'd0;
      end else begin
         if (enter_crit && crit_cnt != 16'hFFFF)
            crit_cnt <= crit_cnt + 16'd1;
         if (enter_noncrit && noncrit_cnt != 16'hFFFF)
            noncrit_cnt <= noncrit_cnt + 16'd1;
      end
   end

   // Running flush residency and its maximum; a stuck flush still updates the max.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_lat       <= 8'd0;
         max_flush_lat <= 8'd0;
      end else if (in_flush) begin
         cur_lat <= cur_lat_inc;
         if (cur_lat_inc > max_flush_lat)
            max_flush_lat <= cur_lat_inc;
      end else begin
         cur_lat <= 8'd0;
      end
   end

endmodule

// File: rtl/uic_intrp_seq.sv
// UIC interrupt entry sequencer (core side).
// Gates UIC request levels with MSR enables, drains the pipeline through a
// flush handshake, saves return state, redirects to the vector and tracks the
// in-service class until rfi/rfci.
// Optional: define UIC_SEQ_STAT_EN to add entry counters and max flush latency.
//
// state  | meaning
// IDLE   | evaluate gated requests, latch class
// FLUSH  | flush_req high, wait for flush_ack, critical may upgrade class
// ENTER  | one-cycle redirect strobe, save SRR/CSRR, set in-service flag
// SETTLE | one cycle for the MSR enable clear to land, no evaluation
module uic_intrp_seq
   import uic_seq_pkg::*;
#(
   parameter logic [31:0] EXT_VEC   = EXT_VEC_DEF,
   parameter logic [31:0] CRIT_VEC  = CRIT_VEC_DEF,
   parameter int          FLUSH_TMO = FLUSH_TMO_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uic_crit_intrp,
   input  logic        uic_noncrit_intrp,
   input  logic [31:0] uicvr,
   input  logic [31:0] msr,
   input  logic [31:0] npc,
   input  logic        flush_ack,
   input  logic        rfi,
   input  logic        rfci,
   output logic        flush_req,
   output logic        except_start,
   output logic [31:0] except_vec,
   output logic        msr_clr_ee,
   output logic        msr_clr_ce,
   output logic [31:0] srr0,
   output logic [31:0] srr1,
   output logic [31:0] csrr0,
   output logic [31:0] csrr1,
   output logic        crit_active,
   output logic        noncrit_active,
   output logic        flush_err
`ifdef UIC_SEQ_STAT_EN
   ,
   output logic [15:0] crit_cnt,
   output logic [15:0] noncrit_cnt,
   output logic [7:0]  max_flush_lat
`endif
);

   localparam int TMO_W = $clog2(FLUSH_TMO + 1);

   seq_state_e       state_q;
   logic             cls_crit;
   logic [TMO_W-1:0] tmo_cnt;
   logic             take_c;
   logic             take_n;

   assign take_c = uic_crit_intrp & msr[MSR_CE];
   assign take_n = uic_noncrit_intrp & msr[MSR_EE] & ~take_c;

   // The vector is taken from uicvr as it stands during the ENTER cycle.
   assign except_vec = !except_start ? 32'd0 :
                       cls_crit      ? crit_target(uicvr, CRIT_VEC) : EXT_VEC;

   // Entry sequencer with registered handshake outputs and return-state capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cls_crit       <= 1'b0;
         tmo_cnt        <= '0;
         flush_req      <= 1'b0;
         except_start   <= 1'b0;
         msr_clr_ee     <= 1'b0;
         msr_clr_ce     <= 1'b0;
         srr0           <= 32'd0;
         srr1           <= 32'd0;
         csrr0          <= 32'd0;
         csrr1          <= 32'd0;
         crit_active    <= 1'b0;
         noncrit_active <= 1'b0;
         flush_err      <= 1'b0;
      end else begin
         // Returns are honoured in every state; an ENTER set below overrides.
         if (rfi)
            noncrit_active <= 1'b0;
         if (rfci)
            crit_active <= 1'b0;

         case (state_q)
            IDLE: begin
               if (take_c || take_n) begin
                  state_q   <= FLUSH;
                  cls_crit  <= take_c;
                  flush_req <= 1'b1;
                  tmo_cnt   <= '0;
               end
            end

            FLUSH: begin
               // Class may upgrade to critical but never falls back.
               cls_crit <= cls_crit | take_c;
               if (flush_ack) begin
                  state_q      <= ENTER;
                  flush_req    <= 1'b0;
                  except_start <= 1'b1;
                  msr_clr_ee   <= 1'b1;
                  msr_clr_ce   <= cls_crit | take_c;
               end else begin
                  if (tmo_cnt != TMO_W'(FLUSH_TMO))
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  if (tmo_cnt == TMO_W'(FLUSH_TMO - 1))
                     flush_err <= 1'b1;
               end
            end

            ENTER: begin
               state_q      <= SETTLE;
               except_start <= 1'b0;
               msr_clr_ee   <= 1'b0;
               msr_clr_ce   <= 1'b0;
               if (cls_crit) begin
                  csrr0       <= npc;
                  csrr1       <= msr;
                  crit_active <= 1'b1;
               end else begin
                  srr0           <= npc;
                  srr1           <= msr;
                  noncrit_active <= 1'b1;
               end
            end

            SETTLE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef UIC_SEQ_STAT_EN
   uic_seq_stat u_stat (
      .clk           (clk),
      .rst           (rst),
      .in_flush      (state_q == FLUSH),
      .enter_crit    (except_start & cls_crit),
      .enter_noncrit (except_start & ~cls_crit),
      .crit_cnt      (crit_cnt),
      .noncrit_cnt   (noncrit_cnt),
      .max_flush_lat (max_flush_lat)
   );
`endif

endmodule

// File: tb/tb_uic_intrp_seq.sv
// Self-checking bench for uic_intrp_seq: directed scenarios plus randomized
// entries checked against a transaction-level model of the entry rules.
module tb_uic_intrp_seq;

   localparam logic [31:0] EXT_VEC  = 32'h0000_0500;
   localparam logic [31:0] CRIT_VEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        uic_crit_intrp, uic_noncrit_intrp;
   logic [31:0] uicvr, msr, npc;
   logic        flush_ack, rfi, rfci;
   logic        flush_req, except_start, msr_clr_ee, msr_clr_ce;
   logic [31:0] except_vec, srr0, srr1, csrr0, csrr1;
   logic        crit_active, noncrit_active, flush_err;
`ifdef UIC_SEQ_STAT_EN
   logic [15:0] crit_cnt, noncrit_cnt;
   logic [7:0]  max_flush_lat;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: architectural state after each completed entry/return.
   logic [31:0] m_srr0, m_srr1, m_csrr0, m_csrr1;
   bit          m_nact, m_cact;
   int          m_ccnt, m_ncnt, m_maxlat;

   always #5 clk = ~clk;

   uic_intrp_seq dut (
      .clk               (clk),
      .rst               (rst),
      .uic_crit_intrp    (uic_crit_intrp),
      .uic_noncrit_intrp (uic_noncrit_intrp),
      .uicvr             (uicvr),
      .msr               (msr),
      .npc               (npc),
      .flush_ack         (flush_ack),
      .rfi               (rfi),
      .rfci              (rfci),
      .flush_req         (flush_req),
      .except_start      (except_start),
      .except_vec        (except_vec),
      .msr_clr_ee        (msr_clr_ee),
      .msr_clr_ce        (msr_clr_ce),
      .srr0              (srr0),
      .srr1              (srr1),
      .csrr0             (csrr0),
      .csrr1             (csrr1),
      .crit_active       (crit_active),
      .noncrit_active    (noncrit_active),
      .flush_err         (flush_err)
`ifdef UIC_SEQ_STAT_EN
      ,
      .crit_cnt          (crit_cnt),
      .noncrit_cnt       (noncrit_cnt),
      .max_flush_lat     (max_flush_lat)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      m_srr0 = 0; m_srr1 = 0; m_csrr0 = 0; m_csrr1 = 0;
      m_nact = 0; m_cact = 0;
      m_ccnt = 0; m_ncnt = 0; m_maxlat = 0;
   endtask

   // One complete request: drive, expect entry (or no entry if masked), check all effects.
   task automatic run_entry(input bit req_c, input bit req_n, input bit late_c,
                            input bit ret_enter, input int ack_dly,
                            input logic [31:0] npc_v, input logic [31:0] msr_v,
                            input logic [31:0] uicvr_v);
      bit          crit;
      logic [31:0] exp_vec;
      crit = req_c & msr_v[14];
      npc = npc_v; msr = msr_v; uicvr = uicvr_v;
      uic_crit_intrp = req_c; uic_noncrit_intrp = req_n;
      tick();
      if (!(crit || (req_n && msr_v[17]))) begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (flush_req !== 1'b0) begin
               n_errors++; $display("FAIL masked_no_flush: got %b expected 0", flush_req);
            end
            tick();
         end
         uic_crit_intrp = 0; uic_noncrit_intrp = 0;
         return;
      end
      n_checks++;
      if (flush_req !== 1'b1) begin
         n_errors++; $display("FAIL flush_req_latency: got %b expected 1", flush_req);
      end
      uic_crit_intrp = 0; uic_noncrit_intrp = 0;
      for (int k = 0; k < ack_dly; k++) begin
         if (k == 0 && late_c) begin
            uic_crit_intrp = 1;
            if (msr_v[14]) crit = 1;
         end
         tick();
         uic_crit_intrp = 0;
         n_checks++;
         if (flush_req !== 1'b1 || except_start !== 1'b0) begin
            n_errors++; $display("FAIL flush_hold: got req=%b start=%b expected req=1 start=0", flush_req, except_start);
         end
      end
      flush_ack = 1;
      tick();
      flush_ack = 0;
      exp_vec = crit ? ((uicvr_v != 0) ? uicvr_v : CRIT_VEC) : EXT_VEC;
      n_checks++;
      if (except_start !== 1'b1 || flush_req !== 1'b0) begin
         n_errors++; $display("FAIL enter_strobe: got start=%b req=%b expected start=1 req=0", except_start, flush_req);
      end
      n_checks++;
      if (except_vec !== exp_vec) begin
         n_errors++; $display("FAIL except_vec: got %h expected %h", except_vec, exp_vec);
      end
      n_checks++;
      if (msr_clr_ee !== 1'b1 || msr_clr_ce !== crit) begin
         n_errors++; $display("FAIL msr_clr: got ee=%b ce=%b expected ee=1 ce=%b", msr_clr_ee, msr_clr_ce, crit);
      end
      if (ret_enter) begin rfi = 1; rfci = 1; end
      tick();
      rfi = 0; rfci = 0;
      if (ret_enter) begin m_nact = 0; m_cact = 0; end
      if (crit) begin
         m_csrr0 = npc_v; m_csrr1 = msr_v; m_cact = 1;
         if (m_ccnt < 65535) m_ccnt++;
      end else begin
         m_srr0 = npc_v; m_srr1 = msr_v; m_nact = 1;
         if (m_ncnt < 65535) m_ncnt++;
      end
      if (ack_dly + 1 > m_maxlat) m_maxlat = (ack_dly + 1 > 255) ? 255 : ack_dly + 1;
      n_checks++;
      if (except_start !== 1'b0 || msr_clr_ee !== 1'b0 || msr_clr_ce !== 1'b0 || except_vec !== 32'd0) begin
         n_errors++; $display("FAIL strobe_width: got start=%b ee=%b ce=%b vec=%h expected all 0", except_start, msr_clr_ee, msr_clr_ce, except_vec);
      end
      n_checks++;
      if (srr0 !== m_srr0 || srr1 !== m_srr1) begin
         n_errors++; $display("FAIL srr: got %h/%h expected %h/%h", srr0, srr1, m_srr0, m_srr1);
      end
      n_checks++;
      if (csrr0 !== m_csrr0 || csrr1 !== m_csrr1) begin
         n_errors++; $display("FAIL csrr: got %h/%h expected %h/%h", csrr0, csrr1, m_csrr0, m_csrr1);
      end
      n_checks++;
      if (noncrit_active !== m_nact || crit_active !== m_cact) begin
         n_errors++; $display("FAIL active: got n=%b c=%b expected n=%b c=%b", noncrit_active, crit_active, m_nact, m_cact);
      end
      tick();
   endtask

   task automatic do_return(input bit r, input bit rc);
      rfi = r; rfci = rc;
      tick();
      rfi = 0; rfci = 0;
      if (r) m_nact = 0;
      if (rc) m_cact = 0;
      n_checks++;
      if (noncrit_active !== m_nact || crit_active !== m_cact) begin
         n_errors++; $display("FAIL return: got n=%b c=%b expected n=%b c=%b", noncrit_active, crit_active, m_nact, m_cact);
      end
   endtask

   task automatic test_reset;
      rst = 0;
      uic_crit_intrp = 0; uic_noncrit_intrp = 0; flush_ack = 0; rfi = 0; rfci = 0;
      uicvr = 0; msr = 0; npc = 0;
      model_clear();
      repeat (3) tick();
      n_checks++;
      if ({flush_req, except_start, except_vec, msr_clr_ee, msr_clr_ce, srr0, srr1, csrr0, csrr1,
           crit_active, noncrit_active, flush_err} !== '0) begin
         n_errors++; $display("FAIL reset_state: got req=%b start=%b vec=%h srr0=%h csrr0=%h err=%b expected all 0",
                              flush_req, except_start, except_vec, srr0, csrr0, flush_err);
      end
      rst = 1;
      tick();
   endtask

   task automatic test_noncrit;
      run_entry(0, 1, 0, 0, 3, 32'h0000_1000, 32'h0002_0000, 32'h0);
   endtask

   task automatic test_crit;
      run_entry(1, 0, 0, 0, 2, 32'h0000_3000, 32'h0002_4000, 32'h0000_2200);
      run_entry(1, 0, 0, 0, 1, 32'h0000_3004, 32'h0002_4000, 32'h0);
      // Simultaneous request: critical wins.
      run_entry(1, 1, 0, 0, 0, 32'h0000_3008, 32'h0002_4000, 32'h0000_4400);
      // Returns arriving in the ENTER cycle: the class being entered stays set.
      run_entry(1, 0, 0, 1, 1, 32'h0000_300C, 32'h0000_4000, 32'h0000_8800);
   endtask

   task automatic test_upgrade;
      do_return(1, 1);
      run_entry(0, 1, 1, 0, 2, 32'h0000_5000, 32'h0002_4000, 32'h0000_6600);
   endtask

   task automatic test_mask_nest;
      run_entry(0, 1, 0, 0, 1, 32'h0000_7000, 32'h0002_4000, 32'h0);
      msr = 32'h0000_0000;
      uic_noncrit_intrp = 1;
      for (int i = 0; i < 50; i++) begin
         tick();
         n_checks++;
         if (flush_req !== 1'b0) begin
            n_errors++; $display("FAIL ee_mask: got %b expected 0 at cycle %0d", flush_req, i);
         end
      end
      run_entry(1, 1, 0, 0, 2, 32'h0000_7100, 32'h0000_4000, 32'h0000_9900);
      do_return(0, 1);
   endtask

   task automatic test_back_to_back;
      do_return(1, 1);
      msr = 32'h0002_0000; npc = 32'h0000_A000;
      uic_noncrit_intrp = 1;
      for (int e = 0; e < 2; e++) begin
         tick();
         n_checks++;
         if (flush_req !== 1'b1) begin
            n_errors++; $display("FAIL b2b_flush: got %b expected 1 entry %0d", flush_req, e);
         end
         if (e == 1) uic_noncrit_intrp = 0;
         flush_ack = 1;
         tick();
         flush_ack = 0;
         n_checks++;
         if (except_start !== 1'b1 || except_vec !== EXT_VEC) begin
            n_errors++; $display("FAIL b2b_enter: got start=%b vec=%h expected 1/%h", except_start, except_vec, EXT_VEC);
         end
         for (int s = 0; s < 2; s++) begin
            tick();
            n_checks++;
            if (flush_req !== 1'b0) begin
               n_errors++; $display("FAIL b2b_settle: got %b expected 0 step %0d", flush_req, s);
            end
         end
         m_srr0 = 32'h0000_A000; m_srr1 = 32'h0002_0000; m_nact = 1;
         if (m_ncnt < 65535) m_ncnt++;
         if (m_maxlat < 1) m_maxlat = 1;
      end
      n_checks++;
      if (srr0 !== m_srr0 || noncrit_active !== 1'b1) begin
         n_errors++; $display("FAIL b2b_state: got srr0=%h n=%b expected %h/1", srr0, noncrit_active, m_srr0);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 40; it++) begin
         bit          rc, rn, late, re;
         logic [31:0] uv;
         rc   = ($urandom_range(0, 2) == 0);
         rn   = ($urandom_range(0, 3) != 0);
         late = ($urandom_range(0, 3) == 0);
         re   = ($urandom_range(0, 5) == 0);
         uv   = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
         run_entry(rc, rn, late, re, $urandom_range(1, 8), $urandom & 32'hFFFF_FFFC, $urandom, uv);
         if ($urandom_range(0, 2) == 0)
            do_return($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
   endtask

   task automatic test_timeout_reset;
      msr = 32'h0002_0000; uic_noncrit_intrp = 1;
      tick();
      uic_noncrit_intrp = 0;
      n_checks++;
      if (flush_req !== 1'b1 || flush_err !== 1'b0) begin
         n_errors++; $display("FAIL tmo_start: got req=%b err=%b expected 1/0", flush_req, flush_err);
      end
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_checks++;
         if (flush_err !== (i >= 16) || flush_req !== 1'b1) begin
            n_errors++; $display("FAIL flush_timeout: got err=%b req=%b expected err=%b req=1 at cycle %0d",
                                 flush_err, flush_req, (i >= 16), i);
         end
      end
      #2;
      rst = 0;
      #1;
      n_checks++;
      if ({flush_req, except_start, srr0, srr1, csrr0, csrr1, crit_active, noncrit_active, flush_err} !== '0) begin
         n_errors++; $display("FAIL async_reset: got req=%b err=%b srr0=%h csrr0=%h expected all 0",
                              flush_req, flush_err, srr0, csrr0);
      end
      model_clear();
      #2;
      rst = 1;
      tick();
      run_entry(0, 1, 0, 0, 1, 32'h0000_B000, 32'h0002_0000, 32'h0);
   endtask

`ifdef UIC_SEQ_STAT_EN
   task automatic test_stats;
      n_checks++;
      if (crit_cnt !== 16'(m_ccnt) || noncrit_cnt !== 16'(m_ncnt) || max_flush_lat !== 8'(m_maxlat)) begin
         n_errors++; $display("FAIL stat_counts: got c=%0d n=%0d lat=%0d expected c=%0d n=%0d lat=%0d",
                              crit_cnt, noncrit_cnt, max_flush_lat, m_ccnt, m_ncnt, m_maxlat);
      end
      force dut.u_stat.crit_cnt = 16'hFFFF;
      #1;
      release dut.u_stat.crit_cnt;
      m_ccnt = 65535;
      run_entry(1, 0, 0, 0, 1, 32'h0000_C000, 32'h0000_4000, 32'h0);
      n_checks++;
      if (crit_cnt !== 16'hFFFF) begin
         n_errors++; $display("FAIL stat_saturate: got %h expected ffff", crit_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_noncrit();
      test_crit();
      test_upgrade();
      test_mask_nest();
      test_back_to_back();
      test_random();
      test_timeout_reset();
`ifdef UIC_SEQ_STAT_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uic_intrp_seq.md
Name: uic_intrp_seq

Overview:
- Core-side end of the UIC interrupt interface: consumes the critical/non-critical interrupt levels and the vector from the UIC and sequences exception entry into the pipeline.
- Gates requests with MSR enables, drains the pipeline via a flush handshake, saves return state to SRR/CSRR, selects the vector and clears the MSR enable bit.
- Tracks in-service class until rfi/rfci.

Parameters:
- EXT_VEC, 32'h0000_0500: non-critical external interrupt vector.
- CRIT_VEC, 32'h0000_0100: critical vector, used when uicvr == 0.
- FLUSH_TMO, 16: cycles to wait for flush_ack before asserting flush_err (counter width $clog2(FLUSH_TMO+1)).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low (0 = reset).
- uic_crit_intrp, in, 1: critical request level.
- uic_noncrit_intrp, in, 1: non-critical request level.
- uicvr, in, 32: critical vector address from the UIC.
- msr, in, 32: current MSR. Bit 17 is EE; bit 14 is CE.
- npc, in, 32: address of the next instruction to execute.
- flush_ack, in, 1: pipeline drained. Single-cycle pulse.
- rfi, in, 1: return from non-critical. Single-cycle pulse.
- rfci, in, 1: return from critical. Single-cycle pulse.
- flush_req, out, 1: pipeline flush request level.
- except_start, out, 1: one-cycle redirect strobe.
- except_vec, out, 32: redirect target, valid with except_start.
- msr_clr_ee, out, 1: clear MSR.EE, one-cycle pulse with except_start.
- msr_clr_ce, out, 1: clear MSR.CE, one-cycle pulse with except_start.
- srr0, out, 32: saved npc for non-critical entry.
- srr1, out, 32: saved msr for non-critical entry.
- csrr0, out, 32: saved npc for critical entry.
- csrr1, out, 32: saved msr for critical entry.
- crit_active, out, 1: critical handler in service.
- noncrit_active, out, 1: non-critical handler in service.
- flush_err, out, 1: flush timeout seen. Sticky until reset.

Behaviour:
- Reset: state IDLE. All outputs and SRR/CSRR registers are 0.
- Definitions:
  - take_c = uic_crit_intrp & msr[14].
  - take_n = uic_noncrit_intrp & msr[17] & ~take_c.
- States: IDLE, FLUSH, ENTER, SETTLE.
- IDLE:
  - take_c or take_n → FLUSH.
  - Latch cls = critical if take_c, else non-critical.
  - flush_req goes 1 the following cycle (registered).
- FLUSH:
  - flush_req = 1.
  - Upgrade: if cls is non-critical and take_c becomes 1, cls becomes critical. Never downgrades.
  - Request withdrawal does not abort. Entry completes; the handler finds UIC status empty.
  - On flush_ack → ENTER. flush_req drops in the ENTER cycle.
  - Timeout counter increments each FLUSH cycle. At FLUSH_TMO set flush_err and keep waiting.
- ENTER (exactly 1 cycle):
  - except_start = 1.
  - Critical: except_vec = (uicvr != 0) ? uicvr : CRIT_VEC; csrr0 <= npc; csrr1 <= msr; msr_clr_ce = 1; crit_active <= 1.
  - Non-critical: except_vec = EXT_VEC; srr0 <= npc; srr1 <= msr; msr_clr_ee = 1; noncrit_active <= 1.
  - uicvr is sampled in this cycle; the critical entry also carries msr_clr_ee = 1.
  - → SETTLE.
- SETTLE (1 cycle): masks the MSR update latency, so no request is evaluated. → IDLE.
- Returns:
  - rfi clears noncrit_active.
  - rfci clears crit_active.
  - Accepted in any state. A simultaneous set in ENTER wins over the clear.
- Nesting: a critical request may be taken while noncrit_active = 1 (CE still set). A non-critical request is blocked by EE = 0.
- Latency: request at cycle t → flush_req at t+1. flush_ack at cycle a → except_start at a+1.
- Simultaneous crit and noncrit: critical wins. The non-critical request remains pending in the UIC.
- Reset mid-sequence: the sequence is abandoned, all registers clear, and flush_req drops asynchronously.

Optional Feature:
- Macro: UIC_SEQ_STAT_EN.
- Defined: adds outputs crit_cnt[15:0] and noncrit_cnt[15:0], incremented per ENTER of each class, saturating at 16'hFFFF and reset to 0. Also adds max_flush_lat[7:0], the largest FLUSH residency seen, saturating.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package uic_seq_pkg holds:
  - state encoding constants: IDLE = 2'd0, FLUSH = 2'd1, ENTER = 2'd2, SETTLE = 2'd3;
  - MSR bit indices: MSR_EE = 17, MSR_CE = 14;
  - default vectors.
- One sub-module, uic_seq_stat: the saturating counters and max-latency tracker, instantiated only under UIC_SEQ_STAT_EN.

Test Plan:
- Non-critical entry: msr = 32'h0002_0000, noncrit = 1, npc = 32'h1000, flush_ack three cycles after flush_req → except_vec = 32'h500, srr0 = 32'h1000, srr1 = 32'h0002_0000, msr_clr_ee pulse, noncrit_active = 1.
- Critical with vector: msr = 32'h0002_4000, crit = 1, uicvr = 32'h0000_2200 → except_vec = 32'h2200, csrr1 = 32'h0002_4000, both clear pulses. With uicvr = 0 → except_vec = 32'h100.
- Upgrade: noncrit taken, crit asserted during FLUSH → critical entry, srr0/srr1 unchanged, noncrit_active = 0.
- Masking and nesting: EE = 0 with noncrit = 1 → no flush_req for 50 cycles. Then noncrit_active = 1, CE = 1 and crit = 1 → critical entry. rfci → crit_active = 0 while noncrit_active stays 1.
- Timeout and reset: flush_ack withheld 20 cycles (FLUSH_TMO = 16) → flush_err = 1 at cycle 16. Reset asserted in FLUSH → flush_req = 0 immediately and all outputs 0.
- Stats (UIC_SEQ_STAT_EN): 3 critical and 2 non-critical entries → crit_cnt = 3, noncrit_cnt = 2. A forced counter preload of 16'hFFFF stays at FFFF after the next entry.
